// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, data width and baud divider helpers.
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } uart_state_e;

   // Clock cycles per serial bit; truncating division.
   function automatic int unsigned calc_div(input int unsigned clkrate,
                                            input int unsigned baudrate);
      return clkrate / baudrate;
   endfunction

   // Width of a counter that runs 0..div-1.
   function automatic int unsigned cnt_width(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small power-of-two FIFO with a combinational head output.
module uart_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   osc,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
      $error("uart_fifo: DEPTH must be a power of 2 and >= 2");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW:0]      count_q;

   // Storage has no reset; the count alone decides which entries are live.
   always_ff @(posedge osc) begin
      if (push) mem_q[wr_ptr_q] <= din;
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge osc or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == FULL_COUNT);
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter fed by a valid/ready FIFO; shifts bytes out LSB-first.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKRATE  = 12_000_000,
   parameter int unsigned BAUDRATE = 9600,
   parameter int unsigned DEPTH    = 4
) (
   input  logic       osc,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       busy
);

   localparam int unsigned DIV  = calc_div(CLKRATE, BAUDRATE);
   localparam int unsigned CW   = cnt_width(DIV);
   localparam int unsigned BW   = $clog2(DATA_BITS);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   if (DIV < 2) begin : gen_div_check
      $error("uart_tx: CLKRATE/BAUDRATE must be >= 2");
   end

   uart_state_e           state_q;
   logic [CW-1:0]         baud_q;
   logic [BW-1:0]         bit_q;
   logic [DATA_BITS-1:0]  shift_q;
   logic                  tx_q;
   logic                  busy_q;

   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [7:0]            fifo_dout;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                  bit_end;

   assign bit_end   = (baud_q == DIV_LAST);
   assign fifo_push = valid && !fifo_full;
   // Pop from idle, or on the last stop cycle so back-to-back frames have no gap.
   assign fifo_pop  = !fifo_empty &&
                      ((state_q == StIdle) || ((state_q == StStop) && bit_end));

   uart_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .osc   (osc),
      .rst   (rst),
      .push  (fifo_push),
      .din   (data),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Frame sequencer; tx follows the state one cycle later, so every level lasts DIV cycles.
   always_ff @(posedge osc or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         busy_q <= (state_q != StIdle) || (fifo_count != '0);
         case (state_q)
            StIdle: begin
               tx_q <= 1'b1;
               if (!fifo_empty) begin
                  shift_q <= fifo_dout;
                  baud_q  <= '0;
                  state_q <= StStart;
               end
            end
            StStart: begin
               tx_q <= 1'b0;
               if (bit_end) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  state_q <= StData;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            StData: begin
               tx_q <= shift_q[0];
               if (bit_end) begin
                  baud_q  <= '0;
                  shift_q <= shift_q >> 1;
                  if (bit_q == LAST_BIT) state_q <= StStop;
                  else                   bit_q   <= bit_q + 1'b1;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            StStop: begin
               tx_q <= 1'b1;
               if (bit_end) begin
                  baud_q <= '0;
                  if (!fifo_empty) begin
                     shift_q <= fifo_dout;
                     state_q <= StStart;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ready = !fifo_full;
   assign tx    = tx_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model plus directed pins.
module tb_uart_tx;

   localparam int unsigned CLKRATE  = 16;
   localparam int unsigned BAUDRATE = 1;
   localparam int unsigned DEPTH    = 4;
   localparam int          DIV      = CLKRATE / BAUDRATE;
   localparam int          FRAME    = 10 * DIV;

   logic       osc = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data = 8'h00;
   logic       valid = 1'b0;
   logic       ready;
   logic       tx;
   logic       busy;

   int checks = 0;
   int errors = 0;

   uart_tx #(
      .CLKRATE  (CLKRATE),
      .BAUDRATE (BAUDRATE),
      .DEPTH    (DEPTH)
   ) dut (
      .osc   (osc),
      .rst   (rst),
      .data  (data),
      .valid (valid),
      .ready (ready),
      .tx    (tx),
      .busy  (busy)
   );

   always #5 osc = ~osc;

   // Reference model: bytes waiting, the latest frame (byte + start cycle) and
   // the earliest edge at which the next byte may be taken.
   logic [7:0] q[$];
   logic [7:0] fb = 8'h00;
   int         fs = 0;
   bit         has_frame = 0;
   int         free_at = 0;
   int         cyc = 0;
   logic       exp_tx = 1'b1;
   logic       exp_busy = 1'b0;
   logic       exp_ready = 1'b1;
   bit         m_pop;
   bit         m_push;

   function automatic logic line_level(input int t);
      int b;
      if (has_frame && t >= fs && t < fs + FRAME) begin
         b = (t - fs) / DIV;
         if (b == 0) return 1'b0;
         if (b <= 8) return fb[b-1];
      end
      return 1'b1;
   endfunction

   initial forever begin
      @(posedge osc or posedge rst);
      if (rst) begin
         q.delete();
         has_frame = 0;
         free_at   = 0;
         exp_tx    = 1'b1;
         exp_busy  = 1'b0;
         exp_ready = 1'b1;
      end else begin
         exp_tx   = line_level(cyc);
         exp_busy = (q.size() != 0) || (has_frame && cyc >= fs && cyc < fs + FRAME);
         m_pop    = (q.size() != 0) && (cyc >= free_at);
         m_push   = valid && (q.size() < DEPTH);
         if (m_pop) begin
            fb        = q.pop_front();
            fs        = cyc + 1;
            has_frame = 1;
            free_at   = cyc + FRAME;
         end
         if (m_push) q.push_back(data);
         exp_ready = (q.size() < DEPTH);
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, want);
      end
   endtask

   // Every cycle: DUT outputs against the model.
   initial forever begin
      @(negedge osc);
      chk("tx", {31'd0, tx}, {31'd0, exp_tx});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("ready", {31'd0, ready}, {31'd0, exp_ready});
   end

   // Literal line level, applied to both DUT and model.
   task automatic pin(input string name, input logic want);
      chk(name, {31'd0, tx}, {31'd0, want});
      chk({name, "_model"}, {31'd0, exp_tx}, {31'd0, want});
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge osc);
      #1;
   endtask

   task automatic send1(input logic [7:0] b);
      @(negedge osc);
      data  = b;
      valid = 1'b1;
      @(posedge osc);
      #1;
      valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q.size() != 0 || exp_busy || (has_frame && cyc <= fs + FRAME)) && n < 3000) begin
         step(1);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout at %0t: got busy, want idle", $time);
      end
      step(2);
   endtask

   logic       pat55 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
   logic       pat3c [8]  = '{0, 0, 1, 1, 1, 1, 0, 0};
   logic [7:0] burst [6]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
   int         pvals [6]  = '{2, 100, 30, 5, 60, 100};
   int         acc [6];

   initial begin
      int i;
      int guard;
      int p;
      bit r;

      @(negedge osc);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      @(negedge osc);
      @(negedge osc);
      rst = 1'b0;
      step(3);

      // Single byte 0x55: start at k+2, alternating line, busy drops at k+2+FRAME.
      send1(8'h55);
      step(1);
      pin("t1_k1_idle", 1'b1);
      chk("t1_busy_k1", {31'd0, busy}, 32'd1);
      step(1);
      pin("t1_start_first", 1'b0);
      step(DIV - 1);
      pin("t1_start_last", 1'b0);
      step(1);
      pin("t1_bit0_first", 1'b1);
      step(DIV / 2);
      for (int b = 1; b <= 8; b++) begin
         pin($sformatf("t1_mid%0d", b), pat55[b]);
         step(DIV);
      end
      pin("t1_stop_mid", pat55[9]);
      step(DIV / 2 - 1);
      chk("t1_busy_last", {31'd0, busy}, 32'd1);
      step(1);
      chk("t1_busy_drop", {31'd0, busy}, 32'd0);
      wait_idle();

      // Back-to-back 0xA5, 0x3C: no gap between frames.
      send1(8'hA5);
      send1(8'h3C);
      step(FRAME);
      pin("t2_stop_end", 1'b1);
      step(1);
      pin("t2_start2", 1'b0);
      chk("t2_busy", {31'd0, busy}, 32'd1);
      step(DIV + DIV / 2);
      for (int b = 0; b < 8; b++) begin
         pin($sformatf("t2_3c_bit%0d", b), pat3c[b]);
         step(DIV);
      end
      wait_idle();

      // Six bytes with valid held: FIFO fills, sixth waits for the first frame end.
      i = 0;
      guard = 0;
      while (i < 6 && guard < 1000) begin
         @(negedge osc);
         data  = burst[i];
         valid = 1'b1;
         r     = ready;
         @(posedge osc);
         #1;
         if (r) begin
            acc[i] = cyc - 1;
            if (i == 4) chk("t3_full_after5", {31'd0, ready}, 32'd0);
            i++;
         end
         guard++;
      end
      valid = 1'b0;
      chk("t3_all_accepted", i, 6);
      chk("t3_five_gap", acc[4] - acc[0], 4);
      chk("t3_sixth_gap", acc[5] - acc[0], FRAME + 2);
      wait_idle();

      // Reset in data bit 3 of 0xF0 with two bytes queued.
      send1(8'hF0);
      send1(8'hC3);
      send1(8'h3C);
      step(4 * DIV + 3);
      pin("t4_bit3_low", 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("t4_async_tx", {31'd0, tx}, 32'd1);
      chk("t4_async_busy", {31'd0, busy}, 32'd0);
      chk("t4_async_ready", {31'd0, ready}, 32'd1);
      @(negedge osc);
      @(negedge osc);
      rst = 1'b0;
      step(3 * FRAME);
      chk("t4_no_frames_tx", {31'd0, tx}, 32'd1);
      chk("t4_no_frames_busy", {31'd0, busy}, 32'd0);
      send1(8'h81);
      wait_idle();

      // Write during stop of a prior frame: pop on last stop cycle, no idle gap.
      send1(8'h5A);
      step(9 * DIV + 4);
      send1(8'h01);
      step(DIV - 4);
      pin("t6_stop_last", 1'b1);
      chk("t6_busy_stop", {31'd0, busy}, 32'd1);
      step(1);
      pin("t6_start", 1'b0);
      chk("t6_busy_start", {31'd0, busy}, 32'd1);
      step(DIV - 1);
      pin("t6_start_last", 1'b0);
      step(1);
      pin("t6_bit0_first", 1'b1);
      step(DIV - 1);
      pin("t6_bit0_last", 1'b1);
      step(1);
      pin("t6_bit1", 1'b0);
      wait_idle();

      // Random traffic with varying load and one asynchronous reset.
      p = pvals[0];
      for (int c = 0; c < 3000; c++) begin
         @(negedge osc);
         if (c % 500 == 0) p = pvals[c / 500];
         valid = ($urandom_range(0, 99) < p);
         data  = 8'($urandom);
         if (c == 1700) begin
            #2;
            rst = 1'b1;
            @(negedge osc);
            rst = 1'b0;
         end
      end
      @(negedge osc);
      valid = 1'b0;
      wait_idle();
      chk("final_busy", {31'd0, busy}, 32'd0);
      chk("final_tx", {31'd0, tx}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial 8N1 transmitter, the counterpart of the chiptune serial receiver (rx on ui_in[0]).
- Accepts bytes over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each byte out LSB-first on tx at BAUDRATE.
- Provides the return path for status and echo from the chiptune core to the host, and serves as the loopback stimulus source for receiver verification.

Parameters:
- CLKRATE, 12_000_000: osc frequency in Hz.
- BAUDRATE, 9600: serial bit rate. DIV = CLKRATE/BAUDRATE (integer, truncated), 1250 at defaults. DIV >= 2 is required (elaboration check).
- DEPTH, 4: FIFO entries. Must be a power of 2, >= 2.

Ports:
- osc, input, 1: system clock.
- rst, input, 1: asynchronous active-high reset.
- data, input, 8: byte to send.
- valid, input, 1: data is presented.
- ready, output, 1: FIFO can accept a byte. ready = !full, registered-state derived.
- tx, output, 1: serial line. Idle high.
- busy, output, 1: a frame is in progress or the FIFO is non-empty.

Behaviour:
- Reset (async, immediate):
  - tx=1, busy=0, ready=1.
  - FIFO pointers and count are 0. FSM is in IDLE. Baud counter and bit index are 0.
  - Any frame in flight is abandoned; queued bytes are discarded.
- Handshake:
  - A byte is written on a rising osc edge where valid && ready.
  - valid with ready=0 is ignored; no data is latched. A held valid re-tries on a later cycle.
  - data is sampled only on the accepting edge.
- FIFO:
  - Count width is log2(DEPTH)+1. Pointers wrap modulo DEPTH.
  - Push and pop on the same edge leaves count unchanged. This is legal only when count is between 1 and DEPTH-1.
  - No push while full (ready=0). No pop while empty.
- FSM states: IDLE, START, DATA, STOP. tx is registered.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter, and go to START.
  - START: tx=0 for DIV cycles.
  - DATA: tx = shift[0] for DIV cycles per bit. Shift right at each bit end. Bit index runs 0..7, then go to STOP.
  - STOP: tx=1 for DIV cycles. At the last stop cycle: if the FIFO is non-empty, pop and go directly to START (zero idle gap); otherwise go to IDLE.
- Baud counter:
  - Counts 0..DIV-1 and resets at every state entry, so each bit is exactly DIV cycles.
  - A frame is 10*DIV cycles.
- Latency: byte accepted at edge k with transmitter idle and FIFO empty -> pop at edge k+1, tx=0 from edge k+2.
- busy: high from the edge after the first accept until the STOP state ends with the FIFO empty. It is registered.
- Simultaneous write during the pop edge: both occur; count stays unchanged.
- Full FIFO during transmission: ready reasserts the cycle after the pop edge.

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE, START, DATA, STOP).
  - DATA_BITS=8.
  - Function for DIV and counter width ($clog2(DIV)).
  - Shared with the receiver.
- One sub-module: uart_fifo.
  - Parameters: DEPTH, WIDTH=8.
  - Ports: osc, rst, push, din, pop, dout, full, empty, count.
  - Combinational dout from head.
  - The top holds the baud counter, FSM and shift register.

Test Plan:
1. Defaults, idle; single write 0x55 at edge k -> tx falls at k+2; line reads 0,1,0,1,0,1,0,1,0,1 with each level 1250 cycles; busy drops 12500 cycles after k+2.
2. Writes 0xA5 then 0x3C on consecutive cycles -> second start bit begins on the cycle immediately after the first frame's stop ends (no idle high beyond 1250 cycles); 0x3C bit order LSB-first is 0,0,1,1,1,1,0,0.
3. Write 6 bytes back-to-back with valid held -> 1 byte is popped and 4 are queued; ready=0 after the 5th accept; the 6th byte is accepted one cycle after the first pop at end of frame 1; all 6 are transmitted in order with no duplicate.
4. Assert rst mid-DATA bit 3 of 0xF0 with 2 bytes queued -> tx=1, busy=0, ready=1 asynchronously; after release, no frames emitted; a new write 0x81 transmits a correct full frame.
5. Loopback to the chiptune receiver at CLKRATE=12e6, BAUDRATE=9600, sending 0x00, 0xFF, 0x80, 0x7E -> receiver outputs identical bytes with no framing errors.
6. CLKRATE=16, BAUDRATE=1 (DIV=16), write 0x01 while in STOP of a prior frame with the FIFO empty -> pop on the last stop cycle; start follows with no IDLE cycle; bit 0 is high for exactly 16 cycles.
